fp_normalizer: RTL and testbench

- Post-add/subtract normalization stage of the customizable FP ALU.
- Takes a raw mantissa (with carry bit) and exponent, and iteratively shifts until the hidden bit is set, adjusting the exponent one step per cycle.
- Acts as the initiator side of the shift protocol: it computes shift count and direction rather than consuming them, and reports both alongside the normalized result.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_normalizer.sv | 167 ++++++++++++++++
 tb/tb_fp_normalizer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared constants for the FP ALU normalization stage.
package fp_pkg;

  localparam int unsigned MANTISSA_SIZE = 23;
  localparam int unsigned EXPONENT_SIZE = 8;

  // Shift direction, same convention as the shifter.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // All-ones biased exponent for the default exponent width.
  localparam logic [EXPONENT_SIZE-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } norm_state_e;

endpackage

// File: rtl/fp_normalizer.sv
// Iterative post-add normalizer: one single-bit shift and exponent step per cycle.
module fp_normalizer
  import fp_pkg::*;
#(
  parameter int unsigned Mantissa_Size = MANTISSA_SIZE,
  parameter int unsigned Exponent_Size = EXPONENT_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [Mantissa_Size+1:0] mantissa_in,
  input  logic [Exponent_Size-1:0] exponent_in,
  output logic [Mantissa_Size:0]   mantissa_out,
  output logic [Exponent_Size-1:0] exponent_out,
  output logic [Exponent_Size-1:0] no_of_shifts,
  output logic                     direction,
  output logic                     busy,
  output logic                     done,
  output logic                     zero,
  output logic                     underflow,
  output logic                     overflow
);

  localparam int unsigned MW = Mantissa_Size + 2;
  localparam logic [Exponent_Size-1:0] ExpMax = '1;

  norm_state_e            state_q, state_d;
  logic [MW-1:0]          mant_q, mant_d;
  logic [Exponent_Size-1:0] exp_q, exp_d, cnt_q, cnt_d, exp_inc;
  logic                   dir_q, dir_d, ovf_q, ovf_d;

  logic [Mantissa_Size:0]   mant_out_d;
  logic [Exponent_Size-1:0] exp_out_d, shifts_d;
  logic                     direction_d, busy_d, done_d, zero_d, uf_d, of_d;
  logic                     finish;

  assign exp_inc = exp_q + Exponent_Size'(1);

  // Next-state, working datapath and published-result logic.
  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    ovf_d       = ovf_q;
    mant_out_d  = mantissa_out;
    exp_out_d   = exponent_out;
    shifts_d    = no_of_shifts;
    direction_d = direction;
    busy_d      = busy;
    done_d      = 1'b0;
    zero_d      = zero;
    uf_d        = underflow;
    of_d        = overflow;
    finish      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mant_d      = mantissa_in;
          exp_d       = exponent_in;
          cnt_d       = '0;
          dir_d       = DIR_LEFT;
          ovf_d       = 1'b0;
          shifts_d    = '0;
          direction_d = DIR_LEFT;
          zero_d      = 1'b0;
          uf_d        = 1'b0;
          of_d        = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (ovf_q) begin
          // Saturated to infinity on the previous right shift.
          finish     = 1'b1;
          of_d       = 1'b1;
          mant_out_d = '0;
          exp_out_d  = ExpMax;
        end else if (mant_q[MW-1]) begin
          cnt_d = Exponent_Size'(1);
          dir_d = DIR_RIGHT;
          if (exp_q == ExpMax || exp_inc == ExpMax) begin
            ovf_d  = 1'b1;
            mant_d = '0;
            exp_d  = ExpMax;
          end else begin
            mant_d = mant_q >> 1;
            exp_d  = exp_inc;
          end
        end else if (mant_q == '0) begin
          finish     = 1'b1;
          zero_d     = 1'b1;
          mant_out_d = '0;
          exp_out_d  = '0;
        end else if (mant_q[MW-2]) begin
          finish     = 1'b1;
          mant_out_d = mant_q[MW-2:0];
          exp_out_d  = exp_q;
        end else if (exp_q <= Exponent_Size'(1)) begin
          finish     = 1'b1;
          uf_d       = 1'b1;
          mant_out_d = mant_q[MW-2:0];
          exp_out_d  = '0;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - Exponent_Size'(1);
          cnt_d  = cnt_q + Exponent_Size'(1);
          dir_d  = DIR_LEFT;
        end

        if (finish) begin
          shifts_d    = cnt_q;
          direction_d = dir_q;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mant_q       <= '0;
      exp_q        <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      ovf_q        <= 1'b0;
      mantissa_out <= '0;
      exponent_out <= '0;
      no_of_shifts <= '0;
      direction    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      zero         <= 1'b0;
      underflow    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mant_q       <= mant_d;
      exp_q        <= exp_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      ovf_q        <= ovf_d;
      mantissa_out <= mant_out_d;
      exponent_out <= exp_out_d;
      no_of_shifts <= shifts_d;
      direction    <= direction_d;
      busy         <= busy_d;
      done         <= done_d;
      zero         <= zero_d;
      underflow    <= uf_d;
      overflow     <= of_d;
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed bench for fp_normalizer with hand-computed expected results.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [24:0] mantissa_in;
  logic [7:0]  exponent_in;
  logic [23:0] mantissa_out;
  logic [7:0]  exponent_out;
  logic [7:0]  no_of_shifts;
  logic        direction, busy, done, zero, underflow, overflow;

  int checks   = 0;
  int failures = 0;

  fp_normalizer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mantissa_in  (mantissa_in),
    .exponent_in  (exponent_in),
    .mantissa_out (mantissa_out),
    .exponent_out (exponent_out),
    .no_of_shifts (no_of_shifts),
    .direction    (direction),
    .busy         (busy),
    .done         (done),
    .zero         (zero),
    .underflow    (underflow),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Issue one operation; pulse_at>0 re-asserts start for the edge E<pulse_at>.
  task automatic run_op(input string tag, input logic [24:0] m, input logic [7:0] e,
                        input int lat, input logic [23:0] m_exp, input logic [7:0] e_exp,
                        input logic [7:0] sh_exp, input logic dir_exp,
                        input logic [2:0] flags_exp, input int pulse_at);
    int  n;
    bit  busy_ok;
    @(posedge clk); #1;
    mantissa_in = m;
    exponent_in = e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_ok = (busy === 1'b1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == pulse_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        n = i;
        break;
      end
      if (busy !== 1'b1) busy_ok = 0;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " busy_before_done"}, 32'(busy_ok), 1);
    check({tag, " busy_at_done"}, 32'(busy), 0);
    check({tag, " mantissa"}, 32'(mantissa_out), 32'(m_exp));
    check({tag, " exponent"}, 32'(exponent_out), 32'(e_exp));
    check({tag, " shifts"}, 32'(no_of_shifts), 32'(sh_exp));
    check({tag, " direction"}, 32'(direction), 32'(dir_exp));
    check({tag, " flags"}, 32'({zero, underflow, overflow}), 32'(flags_exp));
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, 32'(done), 0);
    check({tag, " result_hold"}, 32'(mantissa_out), 32'(m_exp));
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1;
    start = 1'b0;
    mantissa_in = '0;
    exponent_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset outputs", 32'({mantissa_out, exponent_out}), 0);
    reset = 1'b0;

    // flags are {zero, underflow, overflow}
    run_op("left5",  25'h0062AE6, 8'd100, 6, 24'hC55CC0, 8'd95,  8'd5, 1'b0, 3'b000, 0);
    run_op("right1", 25'h16E2AE6, 8'd127, 2, 24'hB71573, 8'd128, 8'd1, 1'b1, 3'b000, 0);
    run_op("norm",   25'h0800000, 8'd127, 1, 24'h800000, 8'd127, 8'd0, 1'b0, 3'b000, 0);
    run_op("zero",   25'h0000000, 8'd127, 1, 24'h000000, 8'd0,   8'd0, 1'b0, 3'b100, 0);
    run_op("uflow",  25'h0000001, 8'd3,   3, 24'h000004, 8'd0,   8'd2, 1'b0, 3'b010, 0);
    run_op("oflow",  25'h1000000, 8'd254, 2, 24'h000000, 8'd255, 8'd1, 1'b1, 3'b001, 0);
    run_op("oflow_in", 25'h1000000, 8'd255, 2, 24'h000000, 8'd255, 8'd1, 1'b1, 3'b001, 0);
    run_op("restart_ign", 25'h0062AE6, 8'd100, 6, 24'hC55CC0, 8'd95, 8'd5, 1'b0, 3'b000, 2);

    // Reset in the middle of an operation: abort, no done pulse.
    @(posedge clk); #1;
    mantissa_in = 25'h0062AE6;
    exponent_in = 8'd100;
    start = 1'b1;
    @(posedge clk); #1;          // E0
    start = 1'b0;
    saw_done = 0;
    repeat (2) begin
      @(posedge clk); #1;        // E1, E2
      if (done === 1'b1) saw_done = 1;
    end
    reset = 1'b1;
    @(posedge clk); #1;          // E3
    reset = 1'b0;
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    check("abort outputs", 32'({mantissa_out, exponent_out, no_of_shifts}), 0);
    check("abort flags", 32'({direction, zero, underflow, overflow}), 0);
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1;
    end
    check("abort no_done", 32'(saw_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
